noc_output_port: RTL
====================

// Module: noc_output_port
// PURPOSE
//  Transmit side of one router output port (N/S/E/W/L). Muxes the flit chosen by the routing logic's
//  port_select/port_enable, registers it onto the link and tracks credits for the downstream input FIFO.
//  Generates port_full and the one-hot turn vector consumed by the routing logic.
//  Consumes the neighbour's credit_inc as credit_i. One instance per output direction per router.
// PARAMETERS
//  CREDITS   4         downstream input-FIFO depth; initial and maximum credit count (1..15)
//  SRC_MASK  5'b11111  sources eligible for turn, bit order {N,S,E,W,L}; own direction bit cleared
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  asynchronous active-low reset
//  N_data_i     in   8  flit at head of N input FIFO ({X[7:4],Y[3:0]})
//  S_data_i     in   8  flit at head of S input FIFO
//  E_data_i     in   8  flit at head of E input FIFO
//  W_data_i     in   8  flit at head of W input FIFO
//  L_data_i     in   8  flit at head of L input FIFO
//  port_select  in   3  source: 000 N, 001 S, 010 E, 011 W, 100 L; 101-111 invalid
//  port_enable  in   1  transfer request from routing logic this cycle
//  credit_i     in   1  one slot freed in downstream FIFO (neighbour's credit_inc)
//  data_o       out  8  link flit to downstream router
//  valid_o      out  1  data_o valid, one-cycle pulse per flit
//  port_full    out  1  no credits left (credit count == 0)
//  turn         out  5  one-hot source allowed this cycle, {N,S,E,W,L}
//  err_o        out  1  sticky protocol error (only with NOC_OPORT_ERR_EN)
// BEHAVIOUR
//  Reset (async assert, sync deassert): credit = CREDITS, data_o = 0, valid_o = 0, port_full = 0,
//   turn = highest set bit of SRC_MASK, err_o = 0.
//  Send: port_enable=1 AND credit>0 AND select valid at edge t -> data_o = mux(select), valid_o = 1
//   during t+1; credit decrements. Latency 1 cycle. Otherwise valid_o = 0 and data_o holds its value.
//  credit_i=1 -> credit increments. Send and credit_i in the same cycle -> credit unchanged.
//  port_full = (credit == 0), taken from the register, so it carries no combinational path from inputs.
//  port_enable while port_full: flit is not sent, credit unchanged (routing logic keeps the flit).
//  Invalid select with port_enable: nothing is sent.
//  credit_i while credit == CREDITS: credit saturates at CREDITS (no wrap).
//  Counter width $clog2(CREDITS+1), unsigned.
//  Turn: rotates every cycle to the next set SRC_MASK bit in order N->S->E->W->L->N, skipping cleared
//   bits. Single-bit mask holds constant. Rotation is independent of enable/full.
// CONFIGURATION
//  NOC_OPORT_ERR_EN defined: err_o is present. It sets and stays set until reset on any of:
//   enable while full, enable with invalid select, credit overflow, enable when turn bit != select.
//  NOC_OPORT_ERR_EN undefined: err_o port and checking logic are omitted; the same conditions are
//   handled silently as described in BEHAVIOUR.
// STRUCTURE
//  noc_pkg: flit_t (8-bit packed {x,y}), SEL_N..SEL_L localparams, TURN_N..TURN_L one-hot constants,
//   dir_e enum.
//  Sub-module noc_turn_rr (SRC_MASK): turn rotator, reused by every output port.
//  The credit counter and link register stay inline.
// TESTING
//  1 Reset, CREDITS=4 -> valid_o=0, port_full=0, turn=5'b10000, credit count 4, err_o=0.
//  2 Four enables, select=001, S_data_i=8'h23, no credits -> four valid_o pulses, data_o=8'h23,
//    port_full=1 after the 4th; 5th enable -> no pulse, err_o=1.
//  3 Full state, then one credit_i pulse -> port_full=0 next cycle; following enable, select=100,
//    L_data_i=8'h41 -> data_o=8'h41, port_full=1.
//  4 credit=2; enable and credit_i in the same cycle -> one flit sent, credit stays 2, port_full=0.
//  5 SRC_MASK=5'b01011 -> turn sequence 01000, 00010, 00001, 01000 on consecutive cycles.
//  6 credit_i at credit=4 -> credit stays 4 and err_o=1 (macro on); err_o is absent and credit
//    stays 4 (macro off).
//  7 enable with select=101 -> no valid_o pulse, credit unchanged, err_o=1 (macro on).

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router types: flit format, source selects, one-hot turn constants and
// small position helpers used by the turn rotator.
package noc_pkg;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } flit_t;

    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_S = 3'd1,
        DIR_E = 3'd2,
        DIR_W = 3'd3,
        DIR_L = 3'd4
    } dir_e;

    localparam logic [2:0] SEL_N = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_E = 3'd2;
    localparam logic [2:0] SEL_W = 3'd3;
    localparam logic [2:0] SEL_L = 3'd4;

    localparam logic [4:0] TURN_N = 5'b10000;
    localparam logic [4:0] TURN_S = 5'b01000;
    localparam logic [4:0] TURN_E = 5'b00100;
    localparam logic [4:0] TURN_W = 5'b00010;
    localparam logic [4:0] TURN_L = 5'b00001;

    // Turn bit that a given source select must see asserted to be allowed.
    function automatic logic [4:0] sel_turn(input logic [2:0] sel);
        logic [4:0] t;
        case (dir_e'(sel))
            DIR_N:   t = TURN_N;
            DIR_S:   t = TURN_S;
            DIR_E:   t = TURN_E;
            DIR_W:   t = TURN_W;
            DIR_L:   t = TURN_L;
            default: t = 5'b00000;
        endcase
        return t;
    endfunction

    // Bit positions run 4 (N) down to 0 (L); rotation order is descending with wrap.
    function automatic logic [2:0] next_pos(input logic [2:0] pos);
        return (pos == 3'd0) ? 3'd4 : pos - 3'd1;
    endfunction

    function automatic logic [2:0] first_src(input logic [4:0] mask);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_turn_rr.sv
// Turn rotator: advances every cycle to the next enabled source in N->S->E->W->L order.
module noc_turn_rr
    import noc_pkg::*;
#(
    parameter logic [4:0] SRC_MASK = 5'b11111
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] turn_o
);

    logic [2:0] pos_q, pos_d;
    logic [2:0] cand;
    logic       found;

    // Walk up to five positions; a single-bit mask lands back on itself.
    always_comb begin
        pos_d = pos_q;
        cand  = pos_q;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cand = next_pos(cand);
            if (!found && SRC_MASK[cand]) begin
                pos_d = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pos_q <= first_src(SRC_MASK);
        else        pos_q <= pos_d;
    end

    assign turn_o = (SRC_MASK == 5'b00000) ? 5'b00000 : (5'b00001 << pos_q);

endmodule

// File: rtl/noc_output_port.sv
// Router output port: source mux, link register and downstream credit tracking.
// Optional sticky protocol error output err_o is built when NOC_OPORT_ERR_EN is defined.
module noc_output_port
    import noc_pkg::*;
#(
    parameter int         CREDITS  = 4,
    parameter logic [4:0] SRC_MASK = 5'b11111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] N_data_i,
    input  logic [7:0] S_data_i,
    input  logic [7:0] E_data_i,
    input  logic [7:0] W_data_i,
    input  logic [7:0] L_data_i,
    input  logic [2:0] port_select,
    input  logic       port_enable,
    input  logic       credit_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       port_full,
    output logic [4:0] turn
`ifdef NOC_OPORT_ERR_EN
   ,output logic       err_o
`endif
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic [CW-1:0] credit_q, credit_d;
    flit_t         data_q, data_d, mux_flit;
    logic          valid_q;
    logic          sel_ok, send;

    always_comb begin
        mux_flit = '0;
        case (port_select)
            SEL_N:   mux_flit = N_data_i;
            SEL_S:   mux_flit = S_data_i;
            SEL_E:   mux_flit = E_data_i;
            SEL_W:   mux_flit = W_data_i;
            SEL_L:   mux_flit = L_data_i;
            default: mux_flit = '0;
        endcase
    end

    assign sel_ok = (port_select <= SEL_L);
    assign send   = port_enable && (credit_q != '0) && sel_ok;

    // Simultaneous send and credit return cancel; returns at full depth saturate.
    always_comb begin
        credit_d = credit_q;
        if (send && !credit_i)                       credit_d = credit_q - 1'b1;
        else if (credit_i && !send && credit_q != CMAX) credit_d = credit_q + 1'b1;
        data_d = send ? mux_flit : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CMAX;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            credit_q <= credit_d;
            data_q   <= data_d;
            valid_q  <= send;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign port_full = (credit_q == '0);

    noc_turn_rr #(.SRC_MASK(SRC_MASK)) u_turn (
        .clk    (clk),
        .rst_n  (rst_n),
        .turn_o (turn)
    );

`ifdef NOC_OPORT_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (port_enable && (port_full || !sel_ok || ((turn & sel_turn(port_select)) == 5'b00000)))
            err_d = 1'b1;
        if (credit_i && !send && credit_q == CMAX)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_o = err_q;
`endif

endmodule
